// File: rtl/dp_pkg.sv
// Shared encodings for the dp_gen datapath: ALU op codes, bus source
// offsets above the GPR range, and memory-read FSM states.
package dp_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    // Offsets added to NUM_REGS to form the non-GPR bus source codes
    localparam int unsigned SRC_PC  = 0;
    localparam int unsigned SRC_MDR = 1;
    localparam int unsigned SRC_ZLO = 2;
    localparam int unsigned SRC_ZHI = 3;
    localparam int unsigned SRC_HI  = 4;
    localparam int unsigned SRC_LO  = 5;

    typedef logic [0:0] mem_state_t;
    localparam mem_state_t ST_IDLE = 1'b0;
    localparam mem_state_t ST_WAIT = 1'b1;

endpackage

// File: rtl/dp_regfile.sv
// General-purpose register file: one write port, one read port.
// Build option DP_R0_ZERO_EN hardwires GPR0 to zero.
module dp_regfile
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    localparam int SEL_W = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [SEL_W-1:0]  rsel,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

`ifdef DP_R0_ZERO_EN
    assign wr_ok = we && (wsel != '0);
    assign rdata = (rsel == '0) ? '0 : regs[rsel];
`else
    assign wr_ok = we;
    assign rdata = regs[rsel];
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wsel] <= wdata;
        end
    end

endmodule

// File: rtl/dp_gen.sv
// Bus-based datapath: GPRs, PC/IR/MAR/MDR/Y/Z/HI/LO, ALU, shift-add
// multiplier and memory-read FSM. Build option: DP_R0_ZERO_EN.
module dp_gen
    import dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 16,
    localparam int SRC_W = $clog2(NUM_REGS + 8),
    localparam int SEL_W = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [SRC_W-1:0]  bus_src,
    input  logic              gpr_we,
    input  logic [SEL_W-1:0]  gpr_sel,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic [2:0]        alu_op,
    input  logic              IncPC,
    input  logic              Read,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] Mdatain,
    output logic              busy,
    output logic              mul_done,
    output logic [DATA_W-1:0] ir_q,
    output logic [DATA_W-1:0] pc_q,
    output logic [DATA_W-1:0] bus_q
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [SRC_W-1:0] GPR_END = SRC_W'(NUM_REGS);

    logic [DATA_W-1:0]   pc, ir, mar, mdr, y, hi, lo;
    logic [2*DATA_W-1:0] z;
    logic [DATA_W-1:0]   gpr_rd;
    mem_state_t          state;

    logic                mul_active;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] mc, acc, acc_nxt;
    logic [DATA_W-1:0]   mp;
    logic                mul_start, mul_last;

    logic [2:0]          op_eff;
    logic [DATA_W-1:0]   alu_b, alu_y;
    logic [SRC_W-1:0]    src_off;
    logic                is_gpr;

    dp_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clock (clock),
        .clear (clear),
        .we    (gpr_we),
        .wsel  (gpr_sel),
        .wdata (bus_q),
        .rsel  (bus_src[SEL_W-1:0]),
        .rdata (gpr_rd)
    );

    assign is_gpr  = bus_src < GPR_END;
    assign src_off = bus_src - GPR_END;

    always_comb begin
        bus_q = '0;
        unique case (1'b1)
            is_gpr:                          bus_q = gpr_rd;
            src_off == SRC_W'(SRC_PC):  bus_q = pc;
            src_off == SRC_W'(SRC_MDR): bus_q = mdr;
            src_off == SRC_W'(SRC_ZLO): bus_q = z[DATA_W-1:0];
            src_off == SRC_W'(SRC_ZHI): bus_q = z[2*DATA_W-1:DATA_W];
            src_off == SRC_W'(SRC_HI):  bus_q = hi;
            src_off == SRC_W'(SRC_LO):  bus_q = lo;
            default:                         bus_q = '0;
        endcase
    end

    assign op_eff = IncPC ? OP_ADD : alu_op;
    assign alu_b  = IncPC ? DATA_W'(1) : bus_q;

    // NOT is unary on the bus operand so it needs no Y setup
    always_comb begin
        alu_y = '0;
        unique case (op_eff)
            OP_ADD: alu_y = y + alu_b;
            OP_SUB: alu_y = y - alu_b;
            OP_AND: alu_y = y & alu_b;
            OP_OR:  alu_y = y | alu_b;
            OP_SHL: alu_y = y << alu_b[SH_W-1:0];
            OP_SHR: alu_y = y >> alu_b[SH_W-1:0];
            OP_NOT: alu_y = ~alu_b;
            OP_MUL: alu_y = '0;
        endcase
    end

    assign mul_start = Zin && !mul_active && (op_eff == OP_MUL);
    assign mul_last  = mul_active && (cnt == CNT_W'(DATA_W - 1));
    assign acc_nxt   = acc + (mp[0] ? mc : '0);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mul_active <= 1'b0;
            cnt        <= '0;
            mc         <= '0;
            mp         <= '0;
            acc        <= '0;
        end else if (mul_start) begin
            mul_active <= 1'b1;
            cnt        <= '0;
            mc         <= {{DATA_W{1'b0}}, y};
            mp         <= bus_q;
            acc        <= '0;
        end else if (mul_active) begin
            acc <= acc_nxt;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + 1'b1;
            if (mul_last) begin
                mul_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z <= '0;
        end else if (mul_last) begin
            z <= acc_nxt;
        end else if (Zin && !mul_active && !mul_start) begin
            z <= {{DATA_W{1'b0}}, alu_y};
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
        end else if (state == ST_IDLE) begin
            if (Read) begin
                state    <= ST_WAIT;
                mem_addr <= mar;
            end
        end else if (mem_ack) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mdr <= '0;
        end else if (state == ST_WAIT && mem_ack) begin
            mdr <= Mdatain;
        end else if (MDRin) begin
            mdr <= bus_q;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            y   <= '0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            if (PCin)  pc  <= bus_q;
            if (IRin)  ir  <= bus_q;
            if (MARin) mar <= bus_q;
            if (Yin)   y   <= bus_q;
            if (HIin)  hi  <= bus_q;
            if (LOin)  lo  <= bus_q;
        end
    end

    assign mem_req  = (state == ST_WAIT);
    assign busy     = mul_active | mem_req;
    assign mul_done = mul_last;
    assign pc_q     = pc;
    assign ir_q     = ir;

endmodule

// File: doc/dp_gen.md
DP_GEN -- requirements
Module: dp_gen

Interface
REQ-001 Parameter DATA_W, default 32: width of the bus and of every register except Z.
REQ-002 Parameter NUM_REGS, default 16: GPR count; SRC_W = clog2(NUM_REGS+8).
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 clear  in  1  reset, asynchronous, active-low.
REQ-005 bus_src  in  SRC_W  encoded bus source: 0..NUM_REGS-1 GPR; NUM_REGS+0 PC, +1 MDR, +2 Zlo, +3 Zhi, +4 HI, +5 LO; other codes drive 0.
REQ-006 gpr_we  in  1  / gpr_sel  in  clog2(NUM_REGS): GPR write enable and index.
REQ-007 PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin  in  1 each  register load enables from bus.
REQ-008 alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 NOT, 7 MUL.
REQ-009 IncPC  in  1  forces ALU op ADD with B = 1.
REQ-010 Read  in  1  one-cycle memory-read start strobe.
REQ-011 mem_req  out  1 / mem_addr  out  DATA_W / mem_ack  in  1 / Mdatain  in  DATA_W: memory read handshake.
REQ-012 busy  out  1 / mul_done  out  1 / ir_q, pc_q  out  DATA_W / bus_q  out  DATA_W.

Function
REQ-013 bus_q shall be the combinational selection named by bus_src.
REQ-014 Loads shall occur on the rising edge with the enable high; all enables may be active together.
REQ-015 ALU A = Y, B = bus_q; ops 0-6 combinational, result zero-extended to 2*DATA_W, loaded into Z on Zin.
REQ-016 SHL/SHR shall shift by B[clog2(DATA_W)-1:0], logical, zero fill; ADD/SUB wrap modulo 2^DATA_W.
REQ-017 Zin with alu_op MUL while idle shall latch Y and bus_q (unsigned), then run shift-add for exactly DATA_W cycles with busy high.
REQ-018 On the last MUL cycle Z shall receive the full 2*DATA_W product and mul_done shall pulse high for one cycle.
REQ-019 Zin (any op) during an active MUL shall be ignored; Z is unchanged until the MUL completes.
REQ-020 Memory FSM states IDLE, WAIT: Read in IDLE -> WAIT, mem_req=1, mem_addr = MAR captured at Read.
REQ-021 In WAIT, mem_ack=1 shall load MDR from Mdatain and return to IDLE the same edge; mem_req low next cycle.
REQ-022 Read while in WAIT shall be ignored; mem_ack in IDLE shall be ignored.
REQ-023 mem_ack and MDRin on the same edge: memory data wins.
REQ-024 busy = (MUL active) OR (FSM in WAIT); other register loads remain allowed while busy.

Reset
REQ-025 clear low shall immediately zero all GPRs, PC, IR, MAR, MDR, Y, Z, HI, LO, abort MUL and force FSM to IDLE.
REQ-026 During reset busy, mul_done and mem_req are 0; first active edge after release acts normally.

Configuration
REQ-027 Macro DP_R0_ZERO_EN defined: GPR0 reads 0 and its writes are discarded; undefined: GPR0 is an ordinary register.

Structure
REQ-028 Shared package dp_pkg holds the alu_op encodings, bus_src offsets and FSM state type.
REQ-029 GPR array shall be sub-module dp_regfile (one write port, one read port); ALU, multiplier, FSM stay in dp_gen.

Verification
REQ-030 R5=0x0000_0034, Y=R5, bus=R6=0x0000_0045, op AND, Zin -> Zlo=0x0000_0004 next edge.
REQ-031 Y=0xFFFF_FFFF, bus=0x0000_0002, MUL -> busy 32 cycles, mul_done once, Z=0x0000_0001_FFFF_FFFE; Zin mid-run ignored.
REQ-032 MAR=0x10, Read, mem_ack after 3 cycles with Mdatain=0xDEAD_BEEF -> mem_addr=0x10, MDR=0xDEAD_BEEF, second Read in WAIT ignored.
REQ-033 PC=0x7, IncPC+Zin, then bus_src=Zlo+PCin -> PC=0x8; PC=0xFFFF_FFFF -> wraps to 0x0.
REQ-034 clear low mid-MUL and in WAIT -> all state zero, busy=0, mem_req=0 immediately.
REQ-035 With DP_R0_ZERO_EN, write 0x55 to GPR0 -> bus reads 0; without it -> 0x55.
